// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives the synchronous instruction RAM and realigns its
// one-cycle-late data with the issuing PC. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int width_p      = 32,
    parameter int addr_width_p = 12,
    parameter int reset_pc_p   = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    stall_i,
    input  logic                    redirect_i,
    input  logic [addr_width_p-1:0] redirect_pc_i,
    output logic [addr_width_p-1:0] pc_o,
    output logic                    imem_stall_o,
    input  logic [width_p-1:0]      instruction_i,
    output logic [width_p-1:0]      instr_o,
    output logic [addr_width_p-1:0] instr_pc_o,
    output logic                    instr_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             fetch_count_o,
    output logic [31:0]             bubble_count_o
`endif
);

    localparam logic [addr_width_p-1:0] reset_pc_lp = addr_width_p'(reset_pc_p);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } state_e;

    state_e                  state_q, state_d;
    logic [addr_width_p-1:0] pc_q, pc_d;
    logic [addr_width_p-1:0] instr_pc_q, instr_pc_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= BOOT;
            pc_q       <= reset_pc_lp;
            instr_pc_q <= reset_pc_lp;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Redirect beats stall; the RAM only sees a stall when no redirect is pending.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        if (redirect_i) begin
            pc_d    = {redirect_pc_i[addr_width_p-1:2], 2'b00};
            state_d = FLUSH;
        end else if (!stall_i) begin
            pc_d       = pc_q + addr_width_p'(4);
            instr_pc_d = pc_q;
            state_d    = RUN;
        end
    end

    assign pc_o          = pc_q;
    assign imem_stall_o  = stall_i & ~redirect_i;
    assign instr_o       = instruction_i;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = (state_q == RUN) & ~redirect_i;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!stall_i) begin
            if (instr_valid_o) fetch_cnt_d  = fetch_cnt_q + 32'd1;
            else               bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    assign fetch_count_o  = fetch_cnt_q;
    assign bubble_count_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural synchronous instruction RAM and an
// expected-PC scoreboard consumed whenever an instruction is accepted downstream.
module tb_fetch_unit;

    localparam int W = 32;
    localparam int A = 12;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          stall_i = 1'b0;
    logic          redirect_i = 1'b0;
    logic [A-1:0]  redirect_pc_i = '0;
    logic [A-1:0]  pc_o;
    logic          imem_stall_o;
    logic [W-1:0]  instruction_i;
    logic [W-1:0]  instr_o;
    logic [A-1:0]  instr_pc_o;
    logic          instr_valid_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   fetch_count_o;
    logic [31:0]   bubble_count_o;
`endif

    int checks = 0;
    int failures = 0;
    logic [A-1:0] exp_q[$];
    logic [W-1:0] mem [1024];

    fetch_unit #(.width_p(W), .addr_width_p(A), .reset_pc_p(0)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc_o),
        .imem_stall_o  (imem_stall_o),
        .instruction_i (instruction_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count_o (fetch_count_o),
        .bubble_count_o(bubble_count_o)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM: output registered, held while stalled.
    always @(posedge clk) begin
        if (!imem_stall_o) instruction_i <= mem[pc_o[A-1:2]];
    end

    function automatic logic [W-1:0] word_at(input logic [A-1:0] a);
        return 32'hC0DE_0000 + 32'(a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the edge; outputs of that cycle are checked 3 ns later.
    task automatic cyc(input logic s, input logic r, input logic [A-1:0] p);
        @(posedge clk);
        #1;
        stall_i = s;
        redirect_i = r;
        redirect_pc_i = p;
        #3;
    endtask

    always @(negedge clk) begin
        if (!reset_i && instr_valid_o && !stall_i) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_valid observed_pc=%h expected=none", instr_pc_o);
            end
            if (exp_q.size() != 0) begin
                logic [A-1:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", 32'(instr_pc_o), 32'(e));
                chk("sb_instr", instr_o, word_at(e));
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + 32'(i);

        // Reset values without any clock edge
        #2;
        chk("rst_pc", 32'(pc_o), 32'h0);
        chk("rst_instr_pc", 32'(instr_pc_o), 32'h0);
        chk("rst_valid", 32'(instr_valid_o), 32'h0);
        chk("rst_imem_stall", 32'(imem_stall_o), 32'h0);

        for (int k = 0; k < 5; k++) exp_q.push_back(A'(4 * k));
        @(posedge clk);
        #1 reset_i = 1'b0;
        #3;
        chk("boot_valid", 32'(instr_valid_o), 32'h0);
        chk("boot_pc", 32'(pc_o), 32'h0);

        cyc(0, 0, '0);
        chk("c2_valid", 32'(instr_valid_o), 32'h1);
        cyc(0, 0, '0);

        // Stall three cycles while instr_pc_o = 0x8
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, '0);
            chk("stall_valid", 32'(instr_valid_o), 32'h1);
            chk("stall_instr_pc", 32'(instr_pc_o), 32'h8);
            chk("stall_pc", 32'(pc_o), 32'hC);
            chk("stall_instr", instr_o, word_at(A'(8)));
            chk("stall_imem", 32'(imem_stall_o), 32'h1);
        end
        cyc(0, 0, '0);
        cyc(0, 0, '0);
        cyc(0, 0, '0);
        chk("run_pc", 32'(pc_o), 32'h14);

        // Redirect to 0x40
        exp_q.push_back(A'('h40));
        cyc(0, 1, A'('h40));
        chk("redir_n_valid", 32'(instr_valid_o), 32'h0);
        cyc(0, 0, '0);
        chk("redir_n1_valid", 32'(instr_valid_o), 32'h0);
        chk("redir_n1_pc", 32'(pc_o), 32'h40);
        cyc(0, 0, '0);
        chk("redir_n2_valid", 32'(instr_valid_o), 32'h1);

        // Redirect with stall, misaligned target
        exp_q.push_back(A'('h20));
        cyc(1, 1, A'('h23));
        chk("rs_valid", 32'(instr_valid_o), 32'h0);
        chk("rs_imem_stall", 32'(imem_stall_o), 32'h0);
        cyc(0, 0, '0);
        chk("rs_flush_valid", 32'(instr_valid_o), 32'h0);
        chk("rs_align_pc", 32'(pc_o), 32'h20);
        cyc(0, 0, '0);
        chk("rs_target_valid", 32'(instr_valid_o), 32'h1);

        // Stall held in FLUSH
        exp_q.push_back(A'('h80));
        cyc(0, 1, A'('h80));
        for (int k = 0; k < 2; k++) begin
            cyc(1, 0, '0);
            chk("fstall_valid", 32'(instr_valid_o), 32'h0);
            chk("fstall_pc", 32'(pc_o), 32'h80);
        end
        cyc(0, 0, '0);
        chk("fstall_rel_valid", 32'(instr_valid_o), 32'h0);
        cyc(0, 0, '0);
        chk("fstall_target_valid", 32'(instr_valid_o), 32'h1);

        // Back-to-back redirects: only the last target is fetched
        exp_q.push_back(A'('h200));
        cyc(0, 1, A'('h100));
        cyc(0, 1, A'('h200));
        chk("b2b_valid", 32'(instr_valid_o), 32'h0);
        cyc(0, 0, '0);
        chk("b2b_pc", 32'(pc_o), 32'h200);
        cyc(0, 0, '0);

        // Wrap past the top word
        exp_q.push_back(A'('hFF8));
        exp_q.push_back(A'('hFFC));
        exp_q.push_back(A'('h000));
        cyc(0, 1, A'('hFF8));
        cyc(0, 0, '0);
        cyc(0, 0, '0);
        cyc(0, 0, '0);
        chk("wrap_pc", 32'(pc_o), 32'h000);
        cyc(0, 0, '0);

        // Asynchronous reset during FLUSH
        cyc(0, 1, A'('h300));
        cyc(0, 0, '0);
        chk("af_pc", 32'(pc_o), 32'h300);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_pc", 32'(pc_o), 32'h0);
        chk("arst_instr_pc", 32'(instr_pc_o), 32'h0);
        chk("arst_valid", 32'(instr_valid_o), 32'h0);
        chk("arst_sb_empty", 32'(exp_q.size()), 32'h0);

        // 10 fetches plus one redirect after a fresh reset
        for (int k = 0; k < 5; k++) exp_q.push_back(A'(4 * k));
        for (int k = 0; k < 5; k++) exp_q.push_back(A'('h400 + 4 * k));
        @(posedge clk);
        #1 reset_i = 1'b0;
        #3;
        chk("boot2_valid", 32'(instr_valid_o), 32'h0);
        for (int k = 0; k < 5; k++) cyc(0, 0, '0);
        cyc(0, 1, A'('h400));
        cyc(0, 0, '0);
        for (int k = 0; k < 5; k++) cyc(0, 0, '0);
        cyc(1, 0, '0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", fetch_count_o, 32'd10);
        chk("perf_bubble", bubble_count_o, 32'd3);
`endif
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch stage feeding `instruction_memory`. It owns the program counter, drives the byte-addressed PC and stall into the synchronous instruction RAM, and re-aligns the RAM's one-cycle-late read data with the PC that produced it. It handles pipeline stalls and branch/jump redirects. It delivers an `{instruction, pc, valid}` triple to the IF/ID register.

## Interface
- `width_p`, 32, instruction width
- `addr_width_p`, 12, byte-address width; equals `$clog2(depth_p*4)` of the instruction memory
- `reset_pc_p`, 0, PC loaded on reset; must be 4-byte aligned

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock
- `reset_i`  in  1  asynchronous, active-high reset
- `stall_i`  in  1  downstream stall; hold PC and outputs
- `redirect_i`  in  1  branch/jump taken; load `redirect_pc_i`
- `redirect_pc_i`  in  `addr_width_p`  redirect target, byte address
- `pc_o`  out  `addr_width_p`  fetch address to the memory's `pc_i`
- `imem_stall_o`  out  1  to the memory's `stall_i`
- `instruction_i`  in  `width_p`  registered read data from memory
- `instr_o`  out  `width_p`  instruction to IF/ID
- `instr_pc_o`  out  `addr_width_p`  PC of `instr_o`
- `instr_valid_o`  out  1  `instr_o`/`instr_pc_o` valid this cycle

## Operation
- State machine states: BOOT, RUN, FLUSH.
  - State is RUN when memory data corresponds to a live fetch.
  - BOOT and FLUSH mean the memory output is stale.
- `pc_q` drives `pc_o`.
- Per-edge priority:
  1. `redirect_i` → `pc_q <= {redirect_pc_i[addr_width_p-1:2], 2'b00}`; state → FLUSH.
  2. Else `stall_i` → `pc_q`, `instr_pc_q` and state hold.
  3. Else → `pc_q <= pc_q + 4`, `instr_pc_q <= pc_q`, state → RUN.
- Redirect takes priority over stall.
- Low two bits of the redirect target are silently forced to zero.
- `imem_stall_o = stall_i & ~redirect_i`.
- `instr_o = instruction_i` (pass-through; the RAM holds its output while stalled).
- `instr_pc_o = instr_pc_q`.
- `instr_valid_o = (state == RUN) & ~redirect_i`: the wrong-path instruction is killed in the redirect cycle itself.
- PC increment wraps modulo 2^`addr_width_p`; the top word is followed by address 0.

## Timing
- Reset values:
  - `pc_q`, `pc_o`: `reset_pc_p`
  - `instr_pc_o`: `reset_pc_p`
  - state: BOOT
  - `instr_valid_o`: 0
  - `imem_stall_o`: follows `stall_i`
  - `instr_o`: follows memory
- Reset is asynchronous. Asserting it mid-operation (including during FLUSH or a stall) forces the reset values immediately, with no dependency on the clock.
- Fetch latency: address on `pc_o` in cycle N → instruction valid in cycle N+1 when N is unstalled.
- After reset release: BOOT for 1 cycle; the first valid instruction (`reset_pc_p`) appears in the 2nd cycle.
- Redirect in cycle N:
  - N: `instr_valid_o` = 0.
  - N+1: FLUSH bubble, `instr_valid_o` = 0.
  - N+2: target instruction valid, `instr_pc_o` = target.
  - Penalty is 2 invalid cycles.
- Stall in BOOT/FLUSH: the state is held; no progress until `stall_i` drops.
- Back-to-back redirects: each restarts FLUSH; only the last target is fetched.
- Sustained throughput with no stall or redirect: 1 instruction per cycle.

## Configuration
- `FETCH_PERF_CNT_EN`
  - Defined: adds outputs `fetch_count_o` [31:0] and `bubble_count_o` [31:0], both reset to 0 and wrapping at 2^32.
    - `fetch_count_o` increments on cycles with `instr_valid_o & ~stall_i`.
    - `bubble_count_o` increments on cycles with `~instr_valid_o & ~stall_i`.
  - Undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset with `reset_pc_p` = 0, memory preloaded with words 0..4 → cycle 1 invalid; cycles 2–6 show `instr_pc_o` 0x0, 0x4, 0x8, 0xC, 0x10 with matching words and valid = 1.
- `stall_i` high for 3 cycles while `instr_pc_o` = 0x8 → `pc_o`, `instr_o`, `instr_pc_o` and valid held unchanged; after release the next valid `instr_pc_o` is 0xC.
- `redirect_i` with `redirect_pc_i` = 0x40 in cycle N → valid = 0 in N and N+1; N+2 shows `instr_pc_o` = 0x40 and `mem[16]`.
- `redirect_i` together with `stall_i`, `redirect_pc_i` = 0x23 → redirect wins; the target fetched is 0x20, valid after 2 bubbles.
- PC at 0xFFC (`addr_width_p` = 12), no stall → next `pc_o` = 0x000; asynchronous reset pulsed mid-FLUSH → outputs return to reset values without a clock edge.
- With `FETCH_PERF_CNT_EN`: 10 sequential fetches plus one redirect → `fetch_count_o` = 10, `bubble_count_o` = 3 (1 BOOT + 2 redirect).
